// File: rtl/sort_result_checker.sv
// Streaming checker for sorted key output: verifies non-decreasing order and element count,
// latches the first failure, and (with SORT_CHECKSUM_EN defined) accumulates a key checksum.
module sort_result_checker #(
    parameter int DATA_W   = 512,
    parameter int KEY_W    = 32,
    parameter int ELEM_CNT = 1 << 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_EN,
    output logic              DONE,
    output logic              ERR,
    output logic [1:0]        ERR_CODE,
    output logic [31:0]       ERR_IDX,
    output logic [31:0]       ELEM_SEEN,
    output logic [31:0]       CHKSUM,
    output logic [1:0]        dbg_state
);
    localparam int          LANES    = DATA_W / KEY_W;
    localparam logic [31:0] LANES_32 = 32'(LANES);
    localparam logic [31:0] CNT_32   = 32'(ELEM_CNT);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    // Handshake: DIN_EN qualifies DIN for one cycle; no backpressure, a word may arrive every cycle.
    state_t              state;
    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;
    logic [KEY_W-1:0]    prev_last;
    logic                prev_valid;
    logic [LANES-1:0]    viol;
    logic [31:0]         vlane;

    assign dbg_state = state;

    always_comb begin
        viol = '0;
        for (int k = 1; k < LANES; k++) begin
            viol[k] = s1_data[k*KEY_W +: KEY_W] < s1_data[(k-1)*KEY_W +: KEY_W];
        end
        viol[0] = prev_valid && (s1_data[KEY_W-1:0] < prev_last);
        // Scan from the top so the lowest violating lane wins.
        vlane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (viol[k]) vlane = 32'(k);
        end
    end

`ifdef SORT_CHECKSUM_EN
    logic [31:0] word_sum;
    logic [31:0] chk_r;

    always_comb begin
        word_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            word_sum = word_sum + 32'(s1_data[k*KEY_W +: KEY_W]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            chk_r <= '0;
        end else if (s1_valid && !DONE) begin
            chk_r <= chk_r + word_sum;
        end
    end

    assign CHKSUM = chk_r;
`else
    assign CHKSUM = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            prev_last  <= '0;
            prev_valid <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            ERR_CODE   <= 2'd0;
            ERR_IDX    <= '0;
            ELEM_SEEN  <= '0;
        end else begin
            // Stage 1: words are only admitted once armed; FIN words still enter so they flag overrun.
            s1_valid <= DIN_EN && (state != IDLE);
            s1_data  <= DIN;

            if (state == IDLE && START) state <= RUN;

            // Stage 2
            if (s1_valid) begin
                if (DONE) begin
                    if (!ERR) begin
                        ERR      <= 1'b1;
                        ERR_CODE <= 2'd2;
                        ERR_IDX  <= CNT_32;
                    end
                end else begin
                    ELEM_SEEN  <= ELEM_SEEN + LANES_32;
                    prev_last  <= s1_data[DATA_W-1 -: KEY_W];
                    prev_valid <= 1'b1;
                    if (|viol && !ERR) begin
                        ERR      <= 1'b1;
                        ERR_CODE <= 2'd1;
                        ERR_IDX  <= ELEM_SEEN + vlane;
                    end
                    if (ELEM_SEEN + LANES_32 == CNT_32) begin
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sort_result_checker.sv
// Scoreboard bench for sort_result_checker with ELEM_CNT=64 (four 16-key words).
module tb_sort_result_checker;
    localparam int DW = 512;

    logic          CLK = 1'b0;
    logic          RST, START, DIN_EN;
    logic [DW-1:0] DIN;
    logic          DONE, ERR;
    logic [1:0]    ERR_CODE, dbg_state;
    logic [31:0]   ERR_IDX, ELEM_SEEN, CHKSUM;

    typedef struct packed {
        logic [31:0] seen;
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [31:0] idx;
        logic [31:0] chk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic en_d1, en_d2;

    sort_result_checker #(.DATA_W(512), .KEY_W(32), .ELEM_CNT(64)) dut (
        .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .DIN_EN(DIN_EN),
        .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE), .ERR_IDX(ERR_IDX),
        .ELEM_SEEN(ELEM_SEEN), .CHKSUM(CHKSUM), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        START  = 1'b0;
        DIN_EN = 1'b0;
        RST    = 1'b1;
        tick();
        tick();
        RST    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ck(input logic [31:0] v);
`ifdef SORT_CHECKSUM_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    function automatic exp_t mk(input logic [31:0] seen, input logic done, input logic err,
                                input logic [1:0] code, input logic [31:0] idx, input logic [31:0] sum);
        exp_t e;
        e.seen = seen; e.done = done; e.err = err; e.code = code; e.idx = idx; e.chk = ck(sum);
        return e;
    endfunction

    function automatic logic [DW-1:0] ramp(input int base);
        logic [DW-1:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = 32'(base + k);
        return w;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [31:0] v);
        logic [DW-1:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = v;
        return w;
    endfunction

    // Driver
    task automatic send(input logic [DW-1:0] w, input exp_t e);
        DIN    = w;
        DIN_EN = 1'b1;
        exp_q.push_back(e);
        tick();
        DIN_EN = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        @(negedge CLK);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
        chk({tag, "_err"}, 32'(ERR), 32'd0);
        chk({tag, "_code"}, 32'(ERR_CODE), 32'd0);
        chk({tag, "_idx"}, ERR_IDX, 32'd0);
        chk({tag, "_seen"}, ELEM_SEEN, 32'd0);
        chk({tag, "_chksum"}, CHKSUM, 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // Monitor: each DIN_EN produces its observable effect two edges later.
    always @(posedge CLK) begin
        if (RST) begin
            en_d1 <= 1'b0;
            en_d2 <= 1'b0;
        end else begin
            en_d1 <= DIN_EN;
            en_d2 <= en_d1;
        end
    end

    always @(negedge CLK) begin
        if (en_d2) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("elem_seen", ELEM_SEEN, e.seen);
                chk("done", 32'(DONE), 32'(e.done));
                chk("err", 32'(ERR), 32'(e.err));
                chk("err_code", 32'(ERR_CODE), 32'(e.code));
                chk("err_idx", ERR_IDX, e.idx);
                chk("chksum", CHKSUM, e.chk);
            end
        end
    end

    initial begin
        logic [DW-1:0] w;
        RST = 1'b1; START = 1'b0; DIN_EN = 1'b0; DIN = '0;
        do_reset();
        @(negedge CLK);
        check_idle("reset");

        // Gating in IDLE, then ramp pass with START dropped during RUN, then overruns.
        tick();
        send(ramp(0), mk(0, 0, 0, 0, 0, 0));
        START = 1'b1;
        tick();
        START = 1'b0;
        send(ramp(0),  mk(16, 0, 0, 0, 0, 120));
        send(ramp(16), mk(32, 0, 0, 0, 0, 496));
        send(ramp(32), mk(48, 0, 0, 0, 0, 1128));
        send(ramp(48), mk(64, 1, 0, 0, 0, 2016));
        send(ramp(64), mk(64, 1, 1, 2, 64, 2016));
        drain();
        chk("fin_state", 32'(dbg_state), 32'd2);
        send(fill(32'd5), mk(64, 1, 1, 2, 64, 2016));
        drain();

        // Intra-word violation: lane 5 of word 1 drops below lane 4.
        do_reset();
        START = 1'b1;
        tick();
        w = ramp(16);
        w[5*32 +: 32] = 32'd3;
        send(ramp(0),  mk(16, 0, 0, 0, 0, 120));
        send(w,        mk(32, 0, 1, 1, 21, 478));
        send(ramp(32), mk(48, 0, 1, 1, 21, 1110));
        send(ramp(48), mk(64, 1, 1, 1, 21, 1998));
        drain();

        // Cross-word violation at index 16.
        do_reset();
        START = 1'b1;
        tick();
        w = ramp(0);
        w[15*32 +: 32] = 32'h100;
        send(w,             mk(16, 0, 0, 0, 0, 361));
        send(fill(32'hFF),  mk(32, 0, 1, 1, 16, 4441));
        send(fill(32'hFF),  mk(48, 0, 1, 1, 16, 8521));
        send(fill(32'h1FF), mk(64, 1, 1, 1, 16, 16697));
        drain();

        // First error wins (7 before 40); equal keys across a word boundary pass.
        do_reset();
        START = 1'b1;
        tick();
        w = ramp(0);
        w[7*32 +: 32]  = 32'd0;
        w[15*32 +: 32] = 32'h100;
        send(w, mk(16, 0, 1, 1, 7, 354));
        send(fill(32'h100), mk(32, 0, 1, 1, 7, 4450));
        w = fill(32'h100);
        w[8*32 +: 32] = 32'h50;
        send(w, mk(48, 0, 1, 1, 7, 8370));
        send(ramp(32'h300), mk(64, 1, 1, 1, 7, 20778));
        drain();

        // All-ones keys: equal keys pass, checksum wraps.
        do_reset();
        START = 1'b1;
        tick();
        send(fill(32'hFFFFFFFF), mk(16, 0, 0, 0, 0, 32'hFFFFFFF0));
        send(fill(32'hFFFFFFFF), mk(32, 0, 0, 0, 0, 32'hFFFFFFE0));
        send(fill(32'hFFFFFFFF), mk(48, 0, 0, 0, 0, 32'hFFFFFFD0));
        send(fill(32'hFFFFFFFF), mk(64, 1, 0, 0, 0, 32'hFFFFFFC0));
        drain();

        // Order error on the completing word: DONE and ERR_CODE=1 together.
        do_reset();
        START = 1'b1;
        tick();
        w = ramp(48);
        w[15*32 +: 32] = 32'd0;
        send(ramp(0),  mk(16, 0, 0, 0, 0, 120));
        send(ramp(16), mk(32, 0, 0, 0, 0, 496));
        send(ramp(32), mk(48, 0, 0, 0, 0, 1128));
        send(w,        mk(64, 1, 1, 1, 63, 1953));
        drain();

        // Reset mid-run, then a clean ramp.
        do_reset();
        START = 1'b1;
        tick();
        send(ramp(0),  mk(16, 0, 0, 0, 0, 120));
        send(ramp(16), mk(32, 0, 0, 0, 0, 496));
        drain();
        do_reset();
        @(negedge CLK);
        check_idle("midrun_reset");
        START = 1'b1;
        tick();
        send(ramp(0),  mk(16, 0, 0, 0, 0, 120));
        send(ramp(16), mk(32, 0, 0, 0, 0, 496));
        send(ramp(32), mk(48, 0, 0, 0, 0, 1128));
        send(ramp(48), mk(64, 1, 0, 0, 0, 2016));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sort_result_checker.md
# sort_result_checker

On-chip checker for sorted output, placed directly downstream of the decompressor in the post-sort DRAM read-back path. It sits on the same word stream that feeds the display FIFO (the decompressed `DRAMW` word, qualified by output-enable bit 0). It inspects every 32-bit key in each 512-bit word and confirms the whole sequence is non-decreasing. It also checks the element count, optionally accumulates a checksum, and latches the first failure so the top level can report pass/fail on ULED and over UART without dumping the full data set.

## Interface
- `DATA_W`, default 512: input word width; must be a multiple of `KEY_W`.
- `KEY_W`, default 32: key width.
- `LANES`, default `DATA_W/KEY_W` (16): keys per word. This is derived and must not be overridden.
- `ELEM_CNT`, default 1<<20: expected total keys; must be a multiple of `LANES` and ≥ `LANES`.
- `CLK`, input, 1: clock.
- `RST`, input, 1: reset (synchronous, active-high).
- `START`, input, 1: level signal; arms the checker. Tied to the performance-counter halt flag.
- `DIN`, input, `DATA_W`: decompressed word. Lane k is `DIN[k*KEY_W +: KEY_W]`; lane 0 is the earliest key in sequence order.
- `DIN_EN`, input, 1: word valid for one cycle. There is no backpressure; the checker accepts a word every cycle.
- `DONE`, output, 1: high once `ELEM_CNT` keys have been checked.
- `ERR`, output, 1: sticky flag; high on the first failure of any kind.
- `ERR_CODE`, output, 2: 0 = none, 1 = order violation, 2 = overrun (word received after `DONE`).
- `ERR_IDX`, output, 32: global key index of the first failure.
- `ELEM_SEEN`, output, 32: keys checked so far.
- `CHKSUM`, output, 32: wrapping sum of all keys (see Configuration).

## Operation
- **FSM states:** `IDLE`, `RUN`, `FIN`.
- **IDLE:** transitions to RUN on the first cycle `START`=1. Any `DIN_EN` seen in IDLE is ignored; no count, no error.
- **RUN:** every `DIN_EN` word enters the check pipeline.
  - `START` is sampled only in IDLE; dropping it in RUN has no effect.
  - RUN transitions to FIN when the word that brings `ELEM_SEEN` to `ELEM_CNT` leaves stage 2.
- **FIN:** terminal until `RST`.
  - `DIN_EN`=1 in FIN raises an overrun: `ERR_CODE`=2 and `ERR_IDX`=`ELEM_CNT`, unless an error is already latched.
  - Counters and the checksum freeze in FIN.
- **Stage 1:** registers `DIN` and `DIN_EN`.
- **Stage 2:**
  - Computes LANES unsigned compares: lane k versus lane k−1, and lane 0 versus `prev_last`.
  - `prev_last` holds lane LANES−1 of the previous accepted word. Before the first word it is invalid, so the lane-0 compare is skipped for word 0.
  - A violation is a key strictly less than its predecessor; equal keys pass.
  - A priority encoder selects the lowest violating lane v. Then `ERR_IDX` = `ELEM_SEEN` + v, using `ELEM_SEEN` before this word's increment.
- **First error wins:** once `ERR` is set, `ERR_CODE` and `ERR_IDX` never change. `ELEM_SEEN` and `CHKSUM` continue updating until FIN.
- **Counter width:** `ELEM_SEEN` increments by LANES per word. It is 32-bit and does not saturate; legal `ELEM_CNT` values never wrap it.
- **Premature end:** if fewer than `ELEM_CNT` keys arrive, `DONE` stays low. Timeout handling belongs to the top level.

## Timing
- Reset values: FSM=IDLE; `DONE`=0, `ERR`=0, `ERR_CODE`=0, `ERR_IDX`=0, `ELEM_SEEN`=0, `CHKSUM`=0; `prev_last` invalid; pipeline valid bits 0.
- **Latency:** a word with `DIN_EN` at cycle t updates `ELEM_SEEN`, `CHKSUM` and error outputs at the cycle t+2 edge, so they are visible from cycle t+2.
  - `DONE` rises in the same cycle as the final `ELEM_SEEN` update.
- **Throughput:** one word per cycle sustained. Back-to-back words must chain `prev_last` correctly, so stage 2 forwards lane LANES−1 of its own word.
- **Simultaneous events:**
  - An order error and the completing word in the same cycle: `DONE`=1 and `ERR_CODE`=1 are both set.
  - An overrun arriving in the cycle `DONE` rises (the word is in stage 1 while the completing word is in stage 2) is flagged as an overrun.
- **Reset:** `RST` mid-RUN flushes the pipeline and returns all outputs to their reset values on the next edge.

## Configuration
- **`SORT_CHECKSUM_EN` defined:** stage 2 contains a LANES-input adder tree. `CHKSUM` accumulates the wrapping (mod 2^32) sum of every checked key, including keys after the first error, and is registered with the same t+2 latency.
- **`SORT_CHECKSUM_EN` undefined:** no adder logic is built and `CHKSUM` is constant 0. All other behaviour is identical.

## Test plan
- **Ramp pass:** `ELEM_CNT`=64; 4 words of keys 0..63, back-to-back, `START` held high → `DONE`=1 two cycles after the 4th `DIN_EN`; `ERR`=0; `ELEM_SEEN`=64; `CHKSUM`=2016 (0 if the macro is off).
- **Intra-word violation:** word 1 has lane 5 = 3 while lane 4 = 20 → `ERR_CODE`=1, `ERR_IDX`=21; `DONE` still rises at 64.
- **Cross-word violation:** word 0 lane 15 = 0x100, word 1 lane 0 = 0xFF → `ERR_IDX`=16. Equal keys (0x100, 0x100) → no error.
- **Overrun and gating:** a word sent in IDLE is ignored (`ELEM_SEEN` stays 0). A 5th word after `DONE` → `ERR_CODE`=2, `ERR_IDX`=64.
- **First-error-wins and wrap:** violations at index 7 then index 40 → `ERR_IDX` stays 7. All keys 0xFFFFFFFF → `CHKSUM`=0xFFFFFFC0.
- **Reset mid-run:** `RST` after 2 words → all outputs 0. A fresh `START` then a full ramp → clean pass.
